// File: rtl/seq_pkg.sv
// Shared constants and types for the beat step sequencer.
package seq_pkg;

   localparam int STEPS  = 16;
   localparam int ADDR_W = 18;
   localparam int BEAT_W = $clog2(STEPS);

   typedef enum logic [0:0] {
      S_IDLE,
      S_RUN
   } seq_state_t;

   typedef logic [BEAT_W-1:0] step_idx_t;

endpackage

// File: rtl/voice_playback_counter.sv
// Per-track sample playback offset counter: restarts on trigger, plays ADDR_NUM
// samples and then goes idle.
module voice_playback_counter #(
   parameter int ADDR_NUM = 64,
   parameter int OFF_W    = (ADDR_NUM > 1) ? $clog2(ADDR_NUM) : 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             trigger_i,
   output logic             active_o,
   output logic [OFF_W-1:0] offset_o
);

   logic             active_q, active_d;
   logic [OFF_W-1:0] offset_q, offset_d;

   // A trigger always wins, so a retrigger during playback restarts at offset 0.
   always_comb begin
      active_d = active_q;
      offset_d = offset_q;
      if (trigger_i) begin
         active_d = 1'b1;
         offset_d = '0;
      end else if (active_q && (offset_q == OFF_W'(ADDR_NUM - 1))) begin
         active_d = 1'b0;
         offset_d = '0;
      end else if (active_q) begin
         offset_d = offset_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         active_q <= 1'b0;
         offset_q <= '0;
      end else begin
         active_q <= active_d;
         offset_q <= offset_d;
      end
   end

   assign active_o = active_q;
   assign offset_o = offset_q;

endmodule

// File: rtl/beat_step_scheduler.sv
// Step sequencer: tempo divider on LRCLK, 16-step beat counter, pattern/mute
// trigger decode and per-track sample-ROM address generation.
//
// state  | meaning
// S_IDLE | stopped; beat held at 0, no step ticks
// S_RUN  | running; tempo divider advances beat, tick at each step start
module beat_step_scheduler
   import seq_pkg::*;
#(
   parameter int NUM_TRACKS = 4,
   parameter int ADDR_NUM   = 64,
   parameter int TEMPO_W    = 16
) (
   input  logic                         LRCLK,
   input  logic                         reset,
   input  logic                         run,
   input  logic [TEMPO_W-1:0]           tempo_div,
   input  logic [NUM_TRACKS*STEPS-1:0]  pattern,
   input  logic [NUM_TRACKS-1:0]        track_mute,
   output logic [BEAT_W-1:0]            beat,
   output logic                         step_tick,
   output logic [NUM_TRACKS-1:0]        voice_active,
   output logic [NUM_TRACKS*ADDR_W-1:0] voice_addr
);

   localparam int OFF_W = (ADDR_NUM > 1) ? $clog2(ADDR_NUM) : 1;

   if (NUM_TRACKS * ADDR_NUM > 2**ADDR_W) begin : g_addr_range_check
      $error("beat_step_scheduler: NUM_TRACKS*ADDR_NUM exceeds the sample-ROM address space");
   end

   seq_state_t         state_q;
   step_idx_t          beat_q;
   logic               step_tick_q;
   logic [TEMPO_W-1:0] tempo_cnt_q;

   logic [TEMPO_W-1:0] div_eff;
   logic [TEMPO_W-1:0] cnt_last;
   logic               step_done;
   step_idx_t          beat_next;

   // >= rather than == so that shrinking tempo_div mid-step ticks at once
   // instead of counting all the way round the counter.
   assign div_eff   = (tempo_div < TEMPO_W'(2)) ? TEMPO_W'(2) : tempo_div;
   assign cnt_last  = div_eff - TEMPO_W'(1);
   assign step_done = (tempo_cnt_q >= cnt_last);
   assign beat_next = (beat_q == step_idx_t'(STEPS - 1)) ? '0 : beat_q + 1'b1;

   always_ff @(posedge LRCLK or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         beat_q      <= '0;
         step_tick_q <= 1'b0;
         tempo_cnt_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               beat_q      <= '0;
               tempo_cnt_q <= '0;
               if (run) begin
                  state_q     <= S_RUN;
                  step_tick_q <= 1'b1;
               end else begin
                  step_tick_q <= 1'b0;
               end
            end
            S_RUN: begin
               if (!run) begin
                  state_q     <= S_IDLE;
                  beat_q      <= '0;
                  tempo_cnt_q <= '0;
                  step_tick_q <= 1'b0;
               end else if (step_done) begin
                  beat_q      <= beat_next;
                  tempo_cnt_q <= '0;
                  step_tick_q <= 1'b1;
               end else begin
                  tempo_cnt_q <= tempo_cnt_q + 1'b1;
                  step_tick_q <= 1'b0;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               beat_q      <= '0;
               tempo_cnt_q <= '0;
               step_tick_q <= 1'b0;
            end
         endcase
      end
   end

   assign beat      = beat_q;
   assign step_tick = step_tick_q;

   // Pattern and mute only matter in the tick cycle; stopping does not cut voices.
   for (genvar t = 0; t < NUM_TRACKS; t++) begin : g_voice
      logic [STEPS-1:0] trk_pat;
      logic             trig;
      logic             act;
      logic [OFF_W-1:0] off;

      assign trk_pat = pattern[t*STEPS +: STEPS];
      assign trig    = step_tick_q & trk_pat[beat_q] & ~track_mute[t];

      voice_playback_counter #(
         .ADDR_NUM (ADDR_NUM),
         .OFF_W    (OFF_W)
      ) u_vpc (
         .clk_i     (LRCLK),
         .rst_i     (reset),
         .trigger_i (trig),
         .active_o  (act),
         .offset_o  (off)
      );

      assign voice_active[t]                   = act;
      assign voice_addr[t*ADDR_W +: ADDR_W]    = ADDR_W'(t * ADDR_NUM) + ADDR_W'(off);
   end

endmodule

// File: tb/tb_beat_step_scheduler.sv
// Directed bench for beat_step_scheduler with hand-derived expected values.
module tb_beat_step_scheduler;

   localparam int NT = 4;
   localparam int ST = 16;
   localparam int AW = 18;
   localparam int TW = 16;

   logic             LRCLK = 1'b0;
   logic             reset;
   logic             run;
   logic [TW-1:0]    tempo_div;
   logic [NT*ST-1:0] pattern;
   logic [NT-1:0]    track_mute;
   logic [3:0]       beat;
   logic             step_tick;
   logic [NT-1:0]    voice_active;
   logic [NT*AW-1:0] voice_addr;

   int n_checks = 0;
   int n_fail   = 0;

   beat_step_scheduler #(
      .NUM_TRACKS (NT),
      .ADDR_NUM   (64),
      .TEMPO_W    (TW)
   ) dut (
      .LRCLK        (LRCLK),
      .reset        (reset),
      .run          (run),
      .tempo_div    (tempo_div),
      .pattern      (pattern),
      .track_mute   (track_mute),
      .beat         (beat),
      .step_tick    (step_tick),
      .voice_active (voice_active),
      .voice_addr   (voice_addr)
   );

   always #5 LRCLK = ~LRCLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] addr(input int t);
      return 32'(voice_addr[t*AW +: AW]);
   endfunction

   task automatic step(input int n);
      repeat (n) begin
         @(posedge LRCLK);
         #1;
      end
   endtask

   task automatic do_reset();
      run        = 1'b0;
      tempo_div  = '0;
      pattern    = '0;
      track_mute = '0;
      reset      = 1'b1;
      step(2);
      reset = 1'b0;
      step(1);
   endtask

   initial begin
      int last;
      do_reset();

      // reset state
      check("rst_beat", 32'(beat), 0);
      check("rst_tick", 32'(step_tick), 0);
      check("rst_active", 32'(voice_active), 0);
      for (int t = 0; t < NT; t++) check($sformatf("rst_addr%0d", t), addr(t), 32'(t * 64));

      // test 1: async reset mid-playback
      tempo_div = 4;
      pattern   = 64'h0001_0000;
      run       = 1'b1;
      step(1);
      step(31);
      check("t1_pre_active1", 32'(voice_active[1]), 1);
      check("t1_pre_addr1", addr(1), 94);
      check("t1_pre_beat", 32'(beat), 7);
      #2;
      reset = 1'b1;
      #1;
      check("t1_beat", 32'(beat), 0);
      check("t1_tick", 32'(step_tick), 0);
      check("t1_active", 32'(voice_active), 0);
      check("t1_addr1", addr(1), 64);
      check("t1_addr3", addr(3), 192);

      // test 2: tempo 4, track0 on steps 0 and 4
      do_reset();
      tempo_div = 4;
      pattern   = 64'h0011;
      run       = 1'b1;
      step(1);
      check("t2_e0_tick", 32'(step_tick), 1);
      check("t2_e0_beat", 32'(beat), 0);
      check("t2_e0_active", 32'(voice_active[0]), 0);
      for (int n = 1; n <= 65; n++) begin
         step(1);
         last = (n >= 65) ? 65 : (n >= 17) ? 17 : 1;
         check($sformatf("t2_tick_%0d", n), 32'(step_tick), 32'((n % 4) == 0));
         check($sformatf("t2_beat_%0d", n), 32'(beat), 32'((n / 4) % 16));
         check($sformatf("t2_act0_%0d", n), 32'(voice_active[0]), 1);
         check($sformatf("t2_addr0_%0d", n), addr(0), 32'(n - last));
      end

      // test 3: tempo 3, track2 every step -> continuous retrigger
      do_reset();
      tempo_div = 3;
      pattern   = 64'hFFFF_0000_0000;
      run       = 1'b1;
      step(1);
      for (int n = 1; n <= 30; n++) begin
         step(1);
         check($sformatf("t3_act2_%0d", n), 32'(voice_active[2]), 1);
         check($sformatf("t3_addr2_%0d", n), addr(2), 32'(128 + (n - 1) % 3));
      end

      // test 4: tempo 0 and 1 clamp to 2; shrink 100 -> 5 mid-step
      do_reset();
      tempo_div = 0;
      run       = 1'b1;
      step(1);
      check("t4_e0_tick", 32'(step_tick), 1);
      for (int n = 1; n <= 16; n++) begin
         if (n == 9) tempo_div = 1;
         step(1);
         check($sformatf("t4_div01_tick_%0d", n), 32'(step_tick), 32'((n % 2) == 0));
         check($sformatf("t4_div01_beat_%0d", n), 32'(beat), 32'(n / 2));
      end
      do_reset();
      tempo_div = 100;
      run       = 1'b1;
      step(1);
      step(50);
      check("t4_c50_tick", 32'(step_tick), 0);
      check("t4_c50_beat", 32'(beat), 0);
      tempo_div = 5;
      for (int n = 51; n <= 61; n++) begin
         step(1);
         check($sformatf("t4_div5_tick_%0d", n), 32'(step_tick), 32'(((n - 51) % 5) == 0));
         check($sformatf("t4_div5_beat_%0d", n), 32'(beat), 32'(1 + (n - 51) / 5));
      end

      // test 5: run dropped 10 cycles into playback; voice plays out
      do_reset();
      tempo_div = 4;
      pattern   = 64'h0001;
      run       = 1'b1;
      step(1);
      step(10);
      check("t5_e10_beat", 32'(beat), 2);
      check("t5_e10_addr0", addr(0), 9);
      run = 1'b0;
      step(1);
      check("t5_stop_beat", 32'(beat), 0);
      check("t5_stop_tick", 32'(step_tick), 0);
      check("t5_stop_act0", 32'(voice_active[0]), 1);
      check("t5_stop_addr0", addr(0), 10);
      step(9);
      check("t5_e20_tick", 32'(step_tick), 0);
      check("t5_e20_beat", 32'(beat), 0);
      step(44);
      check("t5_e64_act0", 32'(voice_active[0]), 1);
      check("t5_e64_addr0", addr(0), 63);
      step(1);
      check("t5_e65_act0", 32'(voice_active[0]), 0);
      check("t5_e65_addr0", addr(0), 0);

      // test 6: muted track3 never fires; unmute takes effect at next tick
      do_reset();
      tempo_div     = 2;
      pattern       = 64'hFFFF_0000_0000_0000;
      track_mute[3] = 1'b1;
      run           = 1'b1;
      step(1);
      for (int n = 1; n <= 9; n++) begin
         step(1);
         check($sformatf("t6_muted_act3_%0d", n), 32'(voice_active[3]), 0);
      end
      track_mute[3] = 1'b0;
      step(1);
      check("t6_e10_tick", 32'(step_tick), 1);
      check("t6_e10_act3", 32'(voice_active[3]), 0);
      step(1);
      check("t6_e11_act3", 32'(voice_active[3]), 1);
      check("t6_e11_addr3", addr(3), 192);
      track_mute[3] = 1'b1;
      step(2);
      check("t6_e13_act3", 32'(voice_active[3]), 1);
      check("t6_e13_addr3", addr(3), 194);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
